// File: rtl/alu16_exec_unit.sv
// rtl/alu16_exec_unit.sv - 16-bit ALU execution unit with request handshake and response FIFO
// Results are computed combinationally on accept and queued with their tag and flags.
module alu16_exec_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [3:0]       req_sel,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      op_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = TAG_W + 20;
  localparam logic [PW:0] LP_FULL = DEPTH[PW:0];

  // Entry layout: {tag, illegal, ovf, zero, carry, result[15:0]}
  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic [15:0]      r_op_count;

  logic [16:0]      w_sum;
  logic [16:0]      w_diff;
  logic [15:0]      w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_ill;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;

  always_comb begin
    w_sum   = {1'b0, req_a} + {1'b0, req_b};
    w_diff  = {1'b0, req_a} - {1'b0, req_b};
    w_res   = 16'h0000;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (req_sel)
      4'b0000: begin
        w_res   = w_sum[15:0];
        w_carry = w_sum[16];
        w_ovf   = (req_a[15] == req_b[15]) && (w_sum[15] != req_a[15]);
      end
      4'b0001: begin
        // Bit 16 of the zero-extended difference is the unsigned borrow.
        w_res   = w_diff[15:0];
        w_carry = w_diff[16];
        w_ovf   = (req_a[15] != req_b[15]) && (w_diff[15] != req_a[15]);
      end
      4'b0010: w_res = req_a & req_b;
      4'b0011: w_res = req_a | req_b;
      4'b0100: w_res = req_a ^ req_b;
      4'b0101: w_res = ~req_a;
      4'b0110: begin
        w_res   = {req_a[14:0], 1'b0};
        w_carry = req_a[15];
      end
      4'b0111: begin
        w_res   = {1'b0, req_a[15:1]};
        w_carry = req_a[0];
      end
      4'b1001: w_res = {15'h0000, req_a == req_b};
      4'b1010: w_res = {15'h0000, req_a > req_b};
      4'b1011: w_res = {15'h0000, req_a < req_b};
      default: w_ill = 1'b1;
    endcase
  end

  assign req_ready = !rst && (r_count != LP_FULL);
  assign rsp_valid = (r_count != '0);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // Empty FIFO presents all-zero response fields, which also covers reset.
  assign rsp_result  = rsp_valid ? w_head[15:0] : 16'h0000;
  assign rsp_carry   = rsp_valid && w_head[16];
  assign rsp_zero    = rsp_valid && w_head[17];
  assign rsp_ovf     = rsp_valid && w_head[18];
  assign rsp_illegal = rsp_valid && w_head[19];
  assign rsp_tag     = rsp_valid ? w_head[EW-1:20] : '0;
  assign op_count    = r_op_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_tag, w_ill, w_ovf, (w_res == 16'h0000), w_carry, w_res};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_op_count <= 16'h0000;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_op_count <= r_op_count + 16'h0001;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_exec_unit.sv
// tb/tb_alu16_exec_unit.sv - directed self-checking bench for alu16_exec_unit
// Inputs change and outputs are sampled on the falling edge.
module tb_alu16_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_sel;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_illegal;
  logic [3:0]  rsp_tag;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu16_exec_unit #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic [15:0] res, input logic c,
                         input logic z, input logic o, input logic il, input logic [3:0] tg);
    chk({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({name, "_flags"}, {16'b0, rsp_result, 7'b0, rsp_carry, rsp_zero, rsp_ovf, rsp_illegal, rsp_tag},
        {16'b0, res, 7'b0, c, z, o, il, tg});
  endtask

  // Present one request for one edge with rsp_ready low; the result is left at the head.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                       input logic [3:0] tg);
    req_a = a; req_b = b; req_sel = sel; req_tag = tg; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
  endtask

  logic [15:0] exp1 [11];
  logic [3:0]  sel1 [11];
  int exp_tag;
  int next_tag;
  logic acc;

  initial begin
    exp1 = '{16'h000D, 16'h0007, 16'h0002, 16'h000B, 16'h0009, 16'hFFF5,
             16'h0014, 16'h0005, 16'h0000, 16'h0001, 16'h0000};
    sel1 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB};
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sel = '0; req_tag = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_op_count", {16'b0, op_count}, 32'd0);
    chk("rst_result", {16'b0, rsp_result}, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Test 1: all legal opcodes back to back, one result per cycle
    rsp_ready = 1'b1;
    req_a = 16'h000A; req_b = 16'h0003;
    for (int i = 0; i < 11; i++) begin
      req_sel = sel1[i]; req_tag = i[3:0]; req_valid = 1'b1;
      @(negedge clk); #1;
      chk($sformatf("t1_valid_%0d", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("t1_res_%0d", i), {12'b0, rsp_tag, rsp_result}, {12'b0, i[3:0], exp1[i]});
    end
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk("t1_empty", {31'b0, rsp_valid}, 32'd0);
    chk("t1_op_count", {16'b0, op_count}, 32'd11);
    rsp_ready = 1'b0;

    // Test 2: arithmetic flag corners
    issue(16'hFFFF, 16'h0001, 4'h0, 4'h1);
    chk_rsp("t2_add_carry", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
    pop_one();
    issue(16'h7FFF, 16'h0001, 4'h0, 4'h2);
    chk_rsp("t2_add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
    pop_one();
    issue(16'h0003, 16'h000A, 4'h1, 4'h3);
    chk_rsp("t2_sub_borrow", 16'hFFF9, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    pop_one();
    issue(16'h8000, 16'h0001, 4'h1, 4'h4);
    chk_rsp("t2_sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4);
    pop_one();
    chk("t2_empty", {31'b0, rsp_valid}, 32'd0);

    // Test 3: fill with rsp_ready low, then drain while issuing the rest
    req_a = 16'h0001; req_b = 16'h0001; req_sel = 4'h0;
    for (int t = 0; t < 4; t++) begin
      req_tag = t[3:0]; req_valid = 1'b1; #1;
      chk($sformatf("t3_ready_%0d", t), {31'b0, req_ready}, 32'd1);
      @(negedge clk);
    end
    req_tag = 4'h4; #1;
    for (int k = 0; k < 2; k++) begin
      chk("t3_full_ready", {31'b0, req_ready}, 32'd0);
      chk("t3_stable_head", {27'b0, rsp_valid, rsp_tag}, {27'b0, 1'b1, 4'h0});
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1; #1;
    chk("t3_ready_low_on_pop", {31'b0, req_ready}, 32'd0);
    exp_tag = 0; next_tag = 4;
    for (int c = 0; c < 40 && exp_tag < 6; c++) begin
      if (c == 1) chk("t3_ready_rises", {31'b0, req_ready}, 32'd1);
      if (rsp_valid) begin
        chk("t3_order", {28'b0, rsp_tag}, exp_tag);
        exp_tag++;
      end
      acc = req_valid && req_ready;
      @(negedge clk);
      if (acc) next_tag++;
      req_tag = next_tag[3:0];
      req_valid = (next_tag < 6);
      #1;
    end
    chk("t3_all_returned", exp_tag, 32'd6);
    chk("t3_empty", {31'b0, rsp_valid}, 32'd0);
    chk("t3_op_count", {16'b0, op_count}, 32'd21);
    rsp_ready = 1'b0; req_valid = 1'b0;

    // Test 4: hold count at 2 with simultaneous push and pop
    issue(16'h0001, 16'h0001, 4'h0, 4'h0);
    issue(16'h0001, 16'h0001, 4'h0, 4'h1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_tag = 4'(i + 2); req_valid = 1'b1; #1;
      chk("t4_ready", {31'b0, req_ready}, 32'd1);
      chk("t4_order", {27'b0, rsp_valid, rsp_tag}, {27'b0, 1'b1, 4'(i)});
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b0; #1;
    chk("t4_op_count", {16'b0, op_count}, 32'd33);
    chk("t4_head", {27'b0, rsp_valid, rsp_tag}, {27'b0, 1'b1, 4'd10});
    pop_one();
    chk("t4_head2", {27'b0, rsp_valid, rsp_tag}, {27'b0, 1'b1, 4'd11});
    pop_one();
    chk("t4_count2", {31'b0, rsp_valid}, 32'd0);

    // Test 5: illegal opcodes
    issue(16'h1234, 16'h5678, 4'hC, 4'h5);
    chk_rsp("t5_ill_1100", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5);
    pop_one();
    issue(16'hFFFF, 16'h0001, 4'h8, 4'h6);
    chk_rsp("t5_ill_1000", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
    pop_one();
    chk("t5_op_count", {16'b0, op_count}, 32'd35);

    // Test 6: reset with entries queued, then a fresh request
    issue(16'h0005, 16'h0006, 4'h0, 4'h7);
    issue(16'h0005, 16'h0006, 4'h1, 4'h8);
    issue(16'h0005, 16'h0006, 4'h2, 4'h9);
    chk("t6_pre_valid", {31'b0, rsp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t6_op_count", {16'b0, op_count}, 32'd0);
    chk("t6_rsp_zero_all", {8'b0, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_illegal, rsp_tag}, 32'd0);
    chk("t6_ready_in_rst", {31'b0, req_ready}, 32'd0);
    rst = 1'b0; #1;
    chk("t6_ready_after", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    issue(16'h0001, 16'h0001, 4'h0, 4'hA);
    chk_rsp("t6_add_after_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
    chk("t6_op_count_after", {16'b0, op_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
